// File: rtl/hwpe_pkg.sv
// Shared constants and FSM encoding for the accumulation stage.
package hwpe_pkg;

  localparam int unsigned ACC_W      = 32;
  localparam logic [31:0] ACC_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] ACC_MIN    = 32'h8000_0000;
  localparam int unsigned PSUM_W_DEF = 20;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN
  } acc_state_e;

endpackage

// File: rtl/acc_sat_lane.sv
// One accumulator lane: 33-bit signed add of acc + psum, clamped to 32 bits.
module acc_sat_lane
  import hwpe_pkg::*;
#(
  parameter int unsigned PSUM_W = PSUM_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PSUM_W-1:0] i_psum,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);

  logic [ACC_W:0] w_acc_ext;
  logic [ACC_W:0] w_psum_ext;
  logic [ACC_W:0] w_sum_ext;

  assign w_acc_ext  = {i_acc[ACC_W-1], i_acc};
  assign w_psum_ext = {{(ACC_W + 1 - PSUM_W){i_psum[PSUM_W-1]}}, i_psum};
  assign w_sum_ext  = w_acc_ext + w_psum_ext;

  // Overflow when the two top bits of the 33-bit sum disagree; bit 32 is the true sign.
  always_comb begin
    o_sat = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];
    o_sum = w_sum_ext[ACC_W-1:0];
    if (o_sat) o_sum = w_sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
  end

endmodule

// File: rtl/acc_bank.sv
// Four-lane saturating accumulator bank with a single-entry output register
// and job sequencing from a start pulse.
module acc_bank
  import hwpe_pkg::*;
#(
  parameter int unsigned PSUM_W = PSUM_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_acc_len,
  input  logic [CNT_W-1:0]  cfg_num_out,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [PSUM_W-1:0] psum_0,
  input  logic [PSUM_W-1:0] psum_1,
  input  logic [PSUM_W-1:0] psum_2,
  input  logic [PSUM_W-1:0] psum_3,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  accreg_0,
  output logic [ACC_W-1:0]  accreg_1,
  output logic [ACC_W-1:0]  accreg_2,
  output logic [ACC_W-1:0]  accreg_3,
  output logic              busy,
  output logic              done,
  output logic              sat_seen
);

  acc_state_e r_state, w_next;

  logic [CNT_W-1:0]  r_len, r_num;
  logic [CNT_W-1:0]  r_beat_cnt, r_grp_cnt;
  logic [ACC_W-1:0]  r_acc    [4];
  logic [ACC_W-1:0]  r_accreg [4];
  logic              r_acc_valid;
  logic              r_sat_seen;

  logic [PSUM_W-1:0] w_psum [4];
  logic [ACC_W-1:0]  w_sum  [4];
  logic [3:0]        w_sat;
  logic              w_last_beat, w_last_grp;
  logic              w_start_ok, w_accept, w_load;
  logic [CNT_W-1:0]  w_cfg_len, w_cfg_num;

  assign w_psum[0] = psum_0;
  assign w_psum[1] = psum_1;
  assign w_psum[2] = psum_2;
  assign w_psum[3] = psum_3;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    acc_sat_lane #(.PSUM_W(PSUM_W)) u_lane (
      .i_acc  (r_acc[g]),
      .i_psum (w_psum[g]),
      .o_sum  (w_sum[g]),
      .o_sat  (w_sat[g])
    );
  end

  assign w_cfg_len   = (cfg_acc_len == '0) ? CNT_W'(1) : cfg_acc_len;
  assign w_cfg_num   = (cfg_num_out == '0) ? CNT_W'(1) : cfg_num_out;
  assign w_last_beat = (r_beat_cnt == r_len - CNT_W'(1));
  assign w_last_grp  = (r_grp_cnt  == r_num - CNT_W'(1));
  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_accept    = psum_valid && psum_ready;
  assign w_load      = w_accept && w_last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_ACC;
      ST_ACC:   if (w_load && w_last_grp) w_next = ST_DRAIN;
      ST_DRAIN: if (!r_acc_valid || acc_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Only a final beat can stall: it needs the output register free or draining.
  always_comb begin
    psum_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      ST_ACC: begin
        busy       = 1'b1;
        psum_ready = !(w_last_beat && r_acc_valid && !acc_ready);
      end
      ST_DRAIN: begin
        busy = 1'b1;
        done = !r_acc_valid || acc_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_num       <= '0;
      r_beat_cnt  <= '0;
      r_grp_cnt   <= '0;
      r_sat_seen  <= 1'b0;
      r_acc_valid <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_acc[i]    <= '0;
        r_accreg[i] <= '0;
      end
    end else begin
      if (w_start_ok) begin
        r_len      <= w_cfg_len;
        r_num      <= w_cfg_num;
        r_beat_cnt <= '0;
        r_grp_cnt  <= '0;
        r_sat_seen <= 1'b0;
        for (int unsigned i = 0; i < 4; i++) r_acc[i] <= '0;
      end else if (w_accept) begin
        if (|w_sat) r_sat_seen <= 1'b1;
        if (w_last_beat) begin
          r_beat_cnt <= '0;
          r_grp_cnt  <= r_grp_cnt + CNT_W'(1);
          for (int unsigned i = 0; i < 4; i++) begin
            r_accreg[i] <= w_sum[i];
            r_acc[i]    <= '0;
          end
        end else begin
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          for (int unsigned i = 0; i < 4; i++) r_acc[i] <= w_sum[i];
        end
      end

      if (w_load)                          r_acc_valid <= 1'b1;
      else if (r_acc_valid && acc_ready)   r_acc_valid <= 1'b0;
    end
  end

  assign acc_valid = r_acc_valid;
  assign accreg_0  = r_accreg[0];
  assign accreg_1  = r_accreg[1];
  assign accreg_2  = r_accreg[2];
  assign accreg_3  = r_accreg[3];
  assign sat_seen  = r_sat_seen;

endmodule
